// File: rtl/mult.sv
// Sequential radix-2 shift-add multiplier producing a 2*WIDTH-bit product.
// Signed operands are multiplied as magnitudes and the result negated in FIX.
module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   result;

    // Negating the most negative value wraps back to itself, which is
    // exactly its unsigned magnitude.
    assign mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
    assign result = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ena) begin
                    neg_d    = (a[WIDTH-1] ^ b[WIDTH-1]) & is_signed;
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = result;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: spec vectors, random operands against an
// arithmetic reference, and the abort / ignore / back-to-back sequences.
module tb_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int tests = 0;
    int failed = 0;

    mult #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .ena(ena),
        .is_signed(is_signed),
        .a(a),
        .b(b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] x,
                                          input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 5)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return $urandom_range(0, 15);
            3: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string name, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp);
        int n;
        is_signed = s;
        a = x;
        b = y;
        ena = 1'b1;
        tick();
        ena = 1'b0;
        a = ~x;
        b = ~y;
        is_signed = ~s;
        chk({name, " busy"}, {63'b0, busy}, 64'd1);
        n = 0;
        while (!done && n < 100) begin
            chk({name, " no done early"}, {63'b0, done}, 64'd0);
            tick();
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'd33);
        chk({name, " result"}, {hi, lo}, exp);
        chk({name, " busy low"}, {63'b0, busy}, 64'd0);
        tick();
        chk({name, " done pulse"}, {63'b0, done}, 64'd0);
        chk({name, " hold"}, {hi, lo}, exp);
    endtask

    vec_t vecs[7];
    logic [31:0] opa[0:140];
    logic [31:0] opb[0:140];
    logic        ops[0:140];

    initial begin
        int bc;
        int dc;
        logic [63:0] first;

        vecs[0] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};

        reset = 1'b0;
        ena = 1'b1;
        is_signed = 1'b0;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        tick();
        tick();
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        ena = 1'b0;
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                   {vecs[i].hi, vecs[i].lo});
        end

        for (int i = 0; i < 30; i++) begin
            logic        s;
            logic [31:0] x, y;
            s = 1'($urandom);
            x = pick();
            y = pick();
            run_op($sformatf("rnd%0d", i), s, x, y, model(s, x, y));
        end

        // ena pulsed mid-operation must be ignored
        first = model(1'b1, 32'hFFFF_FF00, 32'h0001_0003);
        is_signed = 1'b1;
        a = 32'hFFFF_FF00;
        b = 32'h0001_0003;
        ena = 1'b1;
        tick();
        ena = 1'b0;
        bc = busy ? 1 : 0;
        for (int i = 0; i < 60 && busy; i++) begin
            if (i == 9) begin
                ena = 1'b1;
                a = 32'h0000_0005;
                b = 32'h0000_0009;
                is_signed = 1'b0;
            end
            tick();
            ena = 1'b0;
            if (busy) bc++;
        end
        chk("ign busy cycles", 64'(bc), 64'd33);
        chk("ign done", {63'b0, done}, 64'd1);
        chk("ign result", {hi, lo}, first);
        tick();
        chk("ign idle", {63'b0, busy}, 64'd0);

        // reset at cycle 15 aborts
        is_signed = 1'b0;
        a = 32'h0000_0003;
        b = 32'h0000_0004;
        ena = 1'b1;
        tick();
        ena = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("abort pre busy", {63'b0, busy}, 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort busy", {63'b0, busy}, 64'd0);
        chk("abort hi/lo", {hi, lo}, 64'd0);
        dc = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done) dc++;
        end
        chk("abort no done", 64'(dc), 64'd0);
        chk("abort hold", {hi, lo}, 64'd0);

        // ena held high: accepts every 34 edges
        ena = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            ops[k] = 1'($urandom);
            opa[k] = pick();
            opb[k] = pick();
            is_signed = ops[k];
            a = opa[k];
            b = opb[k];
            tick();
            chk($sformatf("b2b done k%0d", k), {63'b0, done},
                {63'b0, (k % 34) == 33});
            if ((k % 34) == 33) begin
                chk($sformatf("b2b result k%0d", k), {hi, lo},
                    model(ops[k-33], opa[k-33], opb[k-33]));
            end
        end
        ena = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("drain idle", {63'b0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
